// File: rtl/aftab_shift_mult_controller.sv
// aftab_shift_mult_controller
//
// Sequencing FSM for the AFTAB shift-add multiplier datapath. A start request
// loads the operand registers and clears the product. Then, for each of the
// `size` multiplier bits, the FSM tests the multiplier LSB, optionally
// accumulates the multiplicand into the product high half, and shifts the
// product and multiplier right by one. Completion is a one-cycle doneMult
// pulse.
//
// Optional feature macro: AFTAB_MULT_ABORT_EN
//   When defined, abortMult in LOAD/TEST/ADD/SHIFT returns the FSM to IDLE
//   without a doneMult pulse. When undefined, abortMult is accepted but ignored.
//
// All outputs are a pure decode of the state register (Moore machine).

module aftab_shift_mult_controller #(
    parameter int unsigned size     = 32,
    parameter int unsigned cntWidth = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic startMult,
    input  logic lsbMultiplier,
    input  logic abortMult,
    output logic ldMultiplicand,
    output logic ldMultiplier,
    output logic initProduct,
    output logic ldAcc,
    output logic shREn,
    output logic busy,
    output logic readyMult,
    output logic doneMult
);

    // Counter value seen in the SHIFT state of the final iteration.
    localparam logic [cntWidth-1:0] LastCnt = cntWidth'(size - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StTest  = 3'd2,
        StAdd   = 3'd3,
        StShift = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [cntWidth-1:0] cnt_q, cnt_d;
    logic                abort_req;

`ifdef AFTAB_MULT_ABORT_EN
    // Abort only counts while an operation is actually in its working states;
    // in DONE the result is already committed, in IDLE there is nothing to stop.
    always_comb begin
        abort_req = 1'b0;
        unique case (state_q)
            StLoad, StTest, StAdd, StShift: abort_req = abortMult;
            default:                        abort_req = 1'b0;
        endcase
    end
`else
    // Port is kept for a uniform interface; the input is intentionally unused.
    logic unused_abort;
    assign unused_abort = abortMult;
    assign abort_req    = 1'b0;
`endif

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (startMult) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StTest;
            end
            StTest: begin
                state_d = lsbMultiplier ? StAdd : StShift;
            end
            StAdd: begin
                state_d = StShift;
            end
            StShift: begin
                cnt_d = cnt_q + 1'b1;
                // Decision uses the pre-increment count.
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    state_d = StTest;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort overrides every other transition.
        if (abort_req) begin
            state_d = StIdle;
        end
    end

    // Output decode from state only.
    always_comb begin
        ldMultiplicand = 1'b0;
        ldMultiplier   = 1'b0;
        initProduct    = 1'b0;
        ldAcc          = 1'b0;
        shREn          = 1'b0;
        busy           = 1'b1;
        readyMult      = 1'b0;
        doneMult       = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy      = 1'b0;
                readyMult = 1'b1;
            end
            StLoad: begin
                ldMultiplicand = 1'b1;
                ldMultiplier   = 1'b1;
                initProduct    = 1'b1;
            end
            StTest: begin
                // Wait state: lets lsbMultiplier settle after LOAD/SHIFT.
            end
            StAdd: begin
                ldAcc = 1'b1;
            end
            StShift: begin
                shREn = 1'b1;
            end
            StDone: begin
                doneMult = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                readyMult = 1'b1;
            end
        endcase
    end

    // Datapath controls must never overlap: the datapath has no priority
    // between accumulate, shift and load.
    property p_ctrl_exclusive;
        @(posedge clk) disable iff (!rst)
            $onehot0({ldMultiplier, ldAcc, shREn, doneMult, readyMult});
    endproperty
    assert property (p_ctrl_exclusive);

    // Every accumulate is immediately followed by a shift.
    property p_acc_then_shift;
        @(posedge clk) disable iff (!rst)
            (ldAcc && !abortMult) |=> (shREn || !rst);
    endproperty
`ifndef AFTAB_MULT_ABORT_EN
    assert property (p_acc_then_shift);
`endif

endmodule
